// File: rtl/display_pkg.sv
// Shared scan-state encoding and active-high 7-segment constants {g,f,e,d,c,b,a}.
package display_pkg;

  typedef enum logic [1:0] {
    DIG_SIGN = 2'd0,
    DIG_TENS = 2'd1,
    DIG_ONES = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Index 0 is the rightmost element: SEG_DIGIT[0] = '0', SEG_DIGIT[9] = '9'.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/result_display_scan_seg7_decode.sv
// BCD digit to active-high 7-segment pattern; codes above 9 show blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  // Table lookup with a blank fallback for non-BCD codes.
  always_comb begin
    pattern = SEG_BLANK;
    if (digit <= 4'd9) begin
      pattern = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/result_display_scan.sv
// Captures the adder/subtractor sum on a synchronised load edge and scans it
// onto a 3-digit multiplexed display as sign, tens, ones.
module result_display_scan
  import display_pkg::*;
#(
  parameter int SCAN_BITS      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       load,
  output logic [4:0] result_q,
  output logic       neg,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam logic [2:0] AN_OFF  = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic                 s1_q, s2_q, s3_q;
  logic                 capture;
  logic [SCAN_BITS-1:0] cnt_q;
  logic                 cnt_wrap;
  scan_state_e          state_q, state_d;
  logic [2:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic [4:0]           mag;
  logic                 tens;
  logic [3:0]           ones;
  logic [6:0]           ones_pat;

  // Two-flop synchroniser for the raw button plus an edge-history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= load;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign capture = s2_q & ~s3_q;

  // Hold the sum captured on the most recent rising edge of load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 5'd0;
    end else if (capture) begin
      result_q <= sum_in;
    end
  end

  assign neg = result_q[4];

  // Magnitude is 0..16; -16 wraps to 5'b10000, which reads as 16 unsigned.
  assign mag  = neg ? (~result_q + 5'd1) : result_q;
  assign tens = (mag >= 5'd10);
  // For 10..16 the low nibble minus 10 (mod 16) gives 0..6, including 16 -> 6.
  assign ones = tens ? (mag[3:0] - 4'd10) : mag[3:0];

  seg7_decode u_ones_decode (
    .digit   (ones),
    .pattern (ones_pat)
  );

  // Free-running dwell counter; its wrap paces the digit scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_wrap = &cnt_q;

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIG_SIGN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next scan state and the digit enable/pattern for the current state.
  always_comb begin
    state_d = state_q;
    an_d    = AN_OFF;
    seg_d   = SEG_OFF;
    unique case (state_q)
      DIG_SIGN: begin
        if (cnt_wrap) state_d = DIG_TENS;
        an_d  = 3'b100;
        seg_d = neg ? SEG_MINUS : SEG_BLANK;
      end
      DIG_TENS: begin
        if (cnt_wrap) state_d = DIG_ONES;
        an_d  = 3'b010;
        seg_d = tens ? SEG_DIGIT[1] : SEG_BLANK;
      end
      DIG_ONES: begin
        if (cnt_wrap) state_d = DIG_SIGN;
        an_d  = 3'b001;
        seg_d = ones_pat;
      end
      default: begin
        state_d = DIG_SIGN;
        an_d    = 3'b000;
        seg_d   = SEG_BLANK;
      end
    endcase
    if (SEG_ACTIVE_LOW) begin
      an_d  = ~an_d;
      seg_d = ~seg_d;
    end
  end

  // Enable and pattern are registered together so they always switch as a pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_result_display_scan.sv
// Directed self-checking bench for result_display_scan (SCAN_BITS=2, active-low).
module tb_result_display_scan;

  logic       clk;
  logic       rst;
  logic [4:0] sum_in;
  logic       load;
  logic [4:0] result_q;
  logic       neg;
  logic [2:0] an;
  logic [6:0] seg;

  int vectors;
  int miscompares;

  // Active-low expected patterns.
  localparam logic [6:0] P_BLANK = 7'h7F;
  localparam logic [6:0] P_MINUS = 7'h3F;
  localparam logic [6:0] P_1     = 7'h79;
  localparam logic [6:0] P_5     = 7'h12;
  localparam logic [6:0] P_6     = 7'h02;
  localparam logic [6:0] P_7     = 7'h78;

  result_display_scan #(
    .SCAN_BITS      (2),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sum_in   (sum_in),
    .load     (load),
    .result_q (result_q),
    .neg      (neg),
    .an       (an),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drop load, then raise it with a new sum and wait for the capture to land.
  task automatic do_load(input logic [4:0] v);
    load = 1'b0;
    repeat (3) @(negedge clk);
    sum_in = v;
    load   = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
  endtask

  // Observe one full scan and record what each digit position showed.
  task automatic grab_digits(output logic [6:0] s_sgn, output logic [6:0] s_tns,
                             output logic [6:0] s_ons, output logic [2:0] seen);
    s_sgn = 'x; s_tns = 'x; s_ons = 'x; seen = 3'b000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        3'b011: begin s_sgn = seg; seen[2] = 1'b1; end
        3'b101: begin s_tns = seg; seen[1] = 1'b1; end
        3'b110: begin s_ons = seg; seen[0] = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic check_display(input string name, input logic [6:0] e_sgn,
                               input logic [6:0] e_tns, input logic [6:0] e_ons);
    logic [6:0] a, b, c;
    logic [2:0] seen;
    grab_digits(a, b, c, seen);
    vectors++;
    if (seen !== 3'b111) begin
      miscompares++;
      $display("FAIL %s_scan: digits seen %b, required 111", name, seen);
    end
    vectors++;
    if (a !== e_sgn) begin
      miscompares++;
      $display("FAIL %s_sign: seg %h, required %h", name, a, e_sgn);
    end
    vectors++;
    if (b !== e_tns) begin
      miscompares++;
      $display("FAIL %s_tens: seg %h, required %h", name, b, e_tns);
    end
    vectors++;
    if (c !== e_ons) begin
      miscompares++;
      $display("FAIL %s_ones: seg %h, required %h", name, c, e_ons);
    end
    $display("vector %s: sign=%h tens=%h ones=%h result_q=%b", name, a, b, c, result_q);
  endtask

  task automatic test_neg16;
    load = 1'b0;
    repeat (3) @(negedge clk);
    sum_in = 5'b10000;
    load   = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (result_q !== 5'b00000) begin
      miscompares++;
      $display("FAIL neg16_early: result_q %b, required 00000 after 2 edges", result_q);
    end
    @(negedge clk);
    vectors++;
    if (result_q !== 5'b10000) begin
      miscompares++;
      $display("FAIL neg16_latency: result_q %b, required 10000 after 3 edges", result_q);
    end
    vectors++;
    if (neg !== 1'b1) begin
      miscompares++;
      $display("FAIL neg16_neg: neg %b, required 1", neg);
    end
    load = 1'b0;
    check_display("neg16", P_MINUS, P_1, P_6);
  endtask

  task automatic test_reset;
    int guard;
    guard = 0;
    while (an !== 3'b101 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (an !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_find_tens: an %b, required 101 within 20 cycles", an);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (an !== 3'b111 || seg !== 7'h7F) begin
      miscompares++;
      $display("FAIL reset_outputs: an %b seg %h, required 111 7f", an, seg);
    end
    vectors++;
    if (result_q !== 5'd0 || neg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_result: result_q %b neg %b, required 00000 0", result_q, neg);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vectors++;
      if (an !== ((i <= 4) ? 3'b011 : 3'b101)) begin
        miscompares++;
        $display("FAIL reset_first_scan: cycle %0d an %b, required %b",
                 i, an, (i <= 4) ? 3'b011 : 3'b101);
      end
    end
    $display("vector reset: an=%b seg=%h result_q=%b", an, seg, result_q);
  endtask

  task automatic test_pos15;
    do_load(5'b01111);
    vectors++;
    if (result_q !== 5'b01111 || neg !== 1'b0) begin
      miscompares++;
      $display("FAIL pos15_result: result_q %b neg %b, required 01111 0", result_q, neg);
    end
    check_display("pos15", P_BLANK, P_1, P_5);
  endtask

  task automatic test_small;
    do_load(5'b00111);
    check_display("pos7", P_BLANK, P_BLANK, P_7);
    do_load(5'b11001);
    vectors++;
    if (result_q !== 5'b11001 || neg !== 1'b1) begin
      miscompares++;
      $display("FAIL neg7_result: result_q %b neg %b, required 11001 1", result_q, neg);
    end
    check_display("neg7", P_MINUS, P_BLANK, P_7);
  endtask

  task automatic test_held_load;
    load = 1'b0;
    repeat (3) @(negedge clk);
    sum_in = 5'b01010;
    load   = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (result_q !== 5'b01010) begin
      miscompares++;
      $display("FAIL held_capture: result_q %b, required 01010", result_q);
    end
    sum_in = 5'b00011;
    repeat (17) @(negedge clk);
    vectors++;
    if (result_q !== 5'b01010) begin
      miscompares++;
      $display("FAIL held_once: result_q %b, required 01010 while load held", result_q);
    end
    load = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (result_q !== 5'b01010) begin
      miscompares++;
      $display("FAIL held_fall: result_q %b, required 01010 after load falls", result_q);
    end
    load = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (result_q !== 5'b00011) begin
      miscompares++;
      $display("FAIL held_reedge: result_q %b, required 00011 after new edge", result_q);
    end
    load = 1'b0;
    $display("vector held_load: result_q=%b", result_q);
  endtask

  task automatic test_scan_timing;
    logic [2:0] prev, want;
    int run, runs_checked;
    prev = an;
    run = 0;
    runs_checked = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an !== 3'b011 && an !== 3'b101 && an !== 3'b110) begin
        vectors++;
        miscompares++;
        $display("FAIL scan_onehot: cycle %0d an %b, required exactly one low", i, an);
      end
      if (an === prev) begin
        run++;
      end else begin
        want = (prev == 3'b011) ? 3'b101 : (prev == 3'b101) ? 3'b110 : 3'b011;
        vectors++;
        if (an !== want) begin
          miscompares++;
          $display("FAIL scan_order: an %b after %b, required %b", an, prev, want);
        end
        if (i > 0 && runs_checked > 0) begin
          vectors++;
          if (run !== 4) begin
            miscompares++;
            $display("FAIL scan_dwell: an %b low for %0d cycles, required 4", prev, run);
          end
        end
        runs_checked++;
        prev = an;
        run = 1;
      end
    end
    vectors++;
    if (runs_checked < 8) begin
      miscompares++;
      $display("FAIL scan_progress: %0d digit changes, required at least 8", runs_checked);
    end
    $display("vector scan_timing: digit changes=%0d", runs_checked);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    load   = 1'b0;
    sum_in = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    test_neg16();
    test_reset();
    test_pos15();
    test_small();
    test_held_load();
    test_scan_timing();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
